// File: rtl/sumador_pkg.sv
// Constants and FSM encoding shared by the 4-bit adder and its accumulator stage.
package sumador_pkg;

  localparam int unsigned ADD_W = 4;
  localparam int unsigned SMP_W = ADD_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/contador_muestras.sv
// Loadable down-counter of remaining samples; last flags the final sample of a run.
module contador_muestras #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= len;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/acumulador_sumas.sv
// Accumulates a programmed number of 5-bit adder results and reports total and overflow.
// Optional feature: ACUMULADOR_SATURATE_EN clamps the total at full scale instead of wrapping.
module acumulador_sumas
  import sumador_pkg::*;
#(
  parameter int unsigned ACC_W = 12,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ADD_W-1:0] in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned SUM_W = ACC_W + 1;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             start_ok;
  logic             xfer;
  logic             last;
  logic [SMP_W-1:0] sample;
  logic [SUM_W-1:0] sum;

  assign start_ok = (state == IDLE) && start;
  assign xfer     = in_valid && in_ready;
  assign sample   = {in_cout, in_sum};
  assign sum      = {1'b0, acc} + SUM_W'(sample);

  contador_muestras #(
    .CNT_W (CNT_W)
  ) u_contador (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .len   (len),
    .dec   (xfer),
    .last  (last)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len != '0) ? ACCUM : DONE;
      ACCUM:   if (xfer && last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stream handshakes decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Accumulator and sticky overflow; carry out of the top bit marks overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (start_ok) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (xfer) begin
      ovf <= ovf | sum[ACC_W];
`ifdef ACUMULADOR_SATURATE_EN
      if (ovf || sum[ACC_W]) begin
        acc <= '1;
      end else begin
        acc <= sum[ACC_W-1:0];
      end
`else
      acc <= sum[ACC_W-1:0];
`endif
    end
  end

  assign out_acc = acc;
  assign out_ovf = ovf;

endmodule

// File: tb/tb_acumulador_sumas.sv
// Directed self-checking bench for acumulador_sumas (honours ACUMULADOR_SATURATE_EN).
module tb_acumulador_sumas;

  localparam int unsigned ACC_W = 12;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_sum;
  logic             in_cout;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  acumulador_sumas #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic arm(input logic [CNT_W-1:0] n);
    start = 1'b1;
    len   = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one sample and hold it until the falling edge after it is accepted.
  task automatic send(input logic [4:0] s);
    int n;
    n = 0;
    in_valid = 1'b1;
    {in_cout, in_sum} = s;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 20) begin
      n_bad++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 400) begin
      n_bad++;
      $display("FAIL done_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, n);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL consume: out_valid=%0b busy=%0b, required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 ||
        out_acc !== 12'd0 || out_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: ov=%0b ir=%0b busy=%0b acc=%0d ovf=%0b, required 0 0 0 0 0",
               out_valid, in_ready, busy, out_acc, out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    arm(8'd4);
    send(5'd3);
    send(5'd4);
    n_cmp++;
    if (out_acc !== 12'd7 || busy !== 1'b1 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_run_partial: acc=%0d busy=%0b ir=%0b, required 7 1 1", out_acc, busy, in_ready);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || out_acc !== 12'd0) begin
      n_bad++;
      $display("FAIL mid_run_reset: ov=%0b ir=%0b busy=%0b acc=%0d, required 0 0 0 0",
               out_valid, in_ready, busy, out_acc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL after_reset_idle: busy=%0b ov=%0b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_basic();
    arm(8'd3);
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_accum: ir=%0b busy=%0b, required 1 1", in_ready, busy);
    end
    // Hold in_valid across three consecutive accepts.
    in_valid = 1'b1;
    {in_cout, in_sum} = 5'b0_0010;
    @(negedge clk);
    {in_cout, in_sum} = 5'b1_0000;
    @(negedge clk);
    {in_cout, in_sum} = 5'b0_1111;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_acc !== 12'd33 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_result: ov=%0b acc=%0d ovf=%0b ir=%0b, required 1 33 0 0",
               out_valid, out_acc, out_ovf, in_ready);
    end
    consume();
  endtask

  task automatic test_empty();
    in_valid = 1'b1;
    {in_cout, in_sum} = 5'd9;
    arm(8'd0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_acc !== 12'd0 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_result: ov=%0b acc=%0d ovf=%0b ir=%0b, required 1 0 0 0",
               out_valid, out_acc, out_ovf, in_ready);
    end
    in_valid = 1'b0;
    consume();
  endtask

  task automatic test_backpressure();
    arm(8'd2);
    repeat (3) @(negedge clk);
    send(5'd5);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || out_acc !== 12'd5) begin
      n_bad++;
      $display("FAIL bubble_hold: ov=%0b busy=%0b acc=%0d, required 0 1 5", out_valid, busy, out_acc);
    end
    send(5'd7);
    // Consumer stalls while a new start is attempted; both must leave the result untouched.
    start = 1'b1;
    len   = 8'd9;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_acc !== 12'd12 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_cycle%0d: ov=%0b acc=%0d ir=%0b, required 1 12 0",
                 i, out_valid, out_acc, in_ready);
      end
      @(negedge clk);
    end
    start = 1'b0;
    consume();
  endtask

  task automatic test_overflow();
    logic [ACC_W-1:0] exp_acc;
`ifdef ACUMULADOR_SATURATE_EN
    exp_acc = 12'd4095;
`else
    exp_acc = 12'd2104;
`endif
    arm(8'd200);
    in_valid = 1'b1;
    {in_cout, in_sum} = 5'b1_1111;
    repeat (200) @(negedge clk);
    in_valid = 1'b0;
    wait_done();
    n_cmp++;
    if (out_acc !== exp_acc || out_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_result: acc=%0d ovf=%0b, required %0d 1", out_acc, out_ovf, exp_acc);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    arm(8'd2);
    n_cmp++;
    if (busy !== 1'b1 || out_ovf !== 1'b0 || out_acc !== 12'd0) begin
      n_bad++;
      $display("FAIL b2b_clear: busy=%0b ovf=%0b acc=%0d, required 1 0 0", busy, out_ovf, out_acc);
    end
    send(5'd31);
    send(5'd1);
    wait_done();
    n_cmp++;
    if (out_acc !== 12'd32 || out_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_result: acc=%0d ovf=%0b, required 32 0", out_acc, out_ovf);
    end
    consume();
  endtask

  initial begin
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_cout   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_reset_mid_run();
    test_basic();
    test_empty();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
